vproc_bus_arbiter: RTL and testbench
====================================

VPROC_BUS_ARBITER -- requirements
Module: vproc_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 0, cycles in BUSY without an ack before forced release; 0 disables the watchdog.
REQ-002 Parameter ERR_DATA, default 64'hDEAD_BEEF_DEAD_BEEF, read data returned on timeout.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 nReset  input  1  reset, asynchronous, active-low.
REQ-005 M_Addr  input  256  four 64-bit master addresses; master i at [64i+63:64i].
REQ-006 M_BE  input  32  four 8-bit byte enables; master i at [8i+7:8i].
REQ-007 M_WE  input  4  per-master write strobe.
REQ-008 M_RD  input  4  per-master read strobe.
REQ-009 M_DataOut  input  256  four 64-bit master write-data buses.
REQ-010 M_Burst  input  48  four 12-bit burst counts; 0 means a single transfer.
REQ-011 M_BurstLast  input  4  per-master last-beat flag.
REQ-012 M_DataIn  output  64  read data broadcast to all masters.
REQ-013 M_WRAck  output  4  per-master write acknowledge.
REQ-014 M_RDAck  output  4  per-master read acknowledge.
REQ-015 S_Addr, S_BE, S_WE, S_RD, S_DataOut  output  64/8/1/1/64  shared slave port.
REQ-016 S_DataIn  input  64  slave read data.
REQ-017 S_WRAck, S_RDAck  input  1  slave acknowledges.
REQ-018 Grant  output  4  one-hot current owner, registered; all zero when idle.
REQ-019 Error  output  1  sticky flag set on timeout.

Function
REQ-020 Request i = M_WE[i] | M_RD[i].
REQ-021 FSM states: IDLE and BUSY.
REQ-022 IDLE with any request active: at the next edge the arbiter registers the owner, sets Grant, and moves to BUSY. Latency from request to slave strobe is one cycle.
REQ-023 Owner selection is round-robin: search starts at LastOwner+1 mod 4 and takes the first active request.
REQ-024 In BUSY, S_Addr/S_BE/S_WE/S_RD/S_DataOut are combinational muxes of the owner's inputs.
REQ-025 In IDLE, S_WE=0 and S_RD=0; the other S_* outputs are 0.
REQ-026 M_DataIn = S_DataIn at all times, except during a timeout cycle.
REQ-027 S_WRAck/S_RDAck are routed only to the owner's M_WRAck/M_RDAck bit; non-owners see 0; IDLE masks all acks.
REQ-028 Release condition: owner ack while owner M_Burst==0 or M_BurstLast==1.
- On release, go to IDLE, clear Grant, set LastOwner = owner.
REQ-029 Ack without the release condition keeps BUSY and ownership, so bursts are never interleaved.
REQ-030 IDLE lasts at least one cycle between grants (one-cycle arbitration gap).
REQ-031 Watchdog counter:
- Clears on entry to BUSY and on every owner ack.
- Increments each BUSY cycle otherwise.
REQ-032 TIMEOUT!=0 and counter==TIMEOUT-1 with no ack in that cycle:
- Drive the owner's ack (M_RDAck if M_RD, else M_WRAck) for one cycle with M_DataIn=ERR_DATA.
- Set Error and release as in REQ-028, regardless of burst state.
REQ-033 If the owner drops both WE and RD while BUSY with no ack, release at the next edge without an ack.
REQ-034 A slave ack arriving in IDLE is ignored.
REQ-035 Error clears only on reset.

Reset
REQ-036 nReset low asynchronously forces:
- state IDLE, Grant=0, LastOwner=3 (master 0 wins first), watchdog=0, Error=0.
- all M_*Ack=0, S_WE=0, S_RD=0.
REQ-037 Reset mid-burst abandons the transfer; no ack is issued.
REQ-038 After nReset rises, arbitration begins at the first posedge.

Verification
REQ-039 Masters 0 and 2 both request in cycle 0 after reset -> Grant=4'b0001 at cycle 1; after master 0's single ack, IDLE for 1 cycle, then Grant=4'b0100.
REQ-040 Master 1 does a 4-beat write burst with Burst=4 and BurstLast on beat 4, while master 3 requests throughout -> Grant stays 4'b0010 through all 4 S_WRAck; master 3 is granted only after the gap.
REQ-041 All four masters request continuously with single reads -> grant order 0,1,2,3,0; each master sees exactly one M_RDAck per grant.
REQ-042 TIMEOUT=8, slave never acks a master 2 read -> on the 8th BUSY cycle M_RDAck[2]=1 with M_DataIn=64'hDEAD_BEEF_DEAD_BEEF, Error=1, then IDLE.
REQ-043 nReset asserted on beat 2 of a burst -> Grant=0 and S_RD/S_WE=0 immediately; after release, master 0 wins if requesting.
REQ-044 Slave ack pulsed while IDLE -> all M_*Ack remain 0.

Source files
------------

// File: rtl/vproc_bus_arbiter.sv
// Four-master round-robin arbiter for a single shared 64-bit slave port.
// Ownership is held across burst beats; an optional watchdog force-releases a stuck owner.
module vproc_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 0,
    parameter logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic [255:0] M_Addr,
    input  logic [31:0]  M_BE,
    input  logic [3:0]   M_WE,
    input  logic [3:0]   M_RD,
    input  logic [255:0] M_DataOut,
    input  logic [47:0]  M_Burst,
    input  logic [3:0]   M_BurstLast,
    output logic [63:0]  M_DataIn,
    output logic [3:0]   M_WRAck,
    output logic [3:0]   M_RDAck,
    output logic [63:0]  S_Addr,
    output logic [7:0]   S_BE,
    output logic         S_WE,
    output logic         S_RD,
    output logic [63:0]  S_DataOut,
    input  logic [63:0]  S_DataIn,
    input  logic         S_WRAck,
    input  logic         S_RDAck,
    output logic [3:0]   Grant,
    output logic         Error
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    localparam bit          WDOG_EN   = (TIMEOUT != 0);
    localparam logic [31:0] WDOG_LAST = TIMEOUT - 32'd1;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  grant_q, grant_d;
    logic [31:0] wdog_q, wdog_d;
    logic        error_q, error_d;

    logic [63:0] addr_arr  [4];
    logic [7:0]  be_arr    [4];
    logic [63:0] dout_arr  [4];
    logic [11:0] burst_arr [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign addr_arr[i]  = M_Addr[64*i +: 64];
        assign be_arr[i]    = M_BE[8*i +: 8];
        assign dout_arr[i]  = M_DataOut[64*i +: 64];
        assign burst_arr[i] = M_Burst[12*i +: 12];
    end

    logic [3:0] req;
    logic       busy;
    logic       own_we, own_rd, own_req;
    logic       own_ack;
    logic       burst_done;
    logic       timeout_hit;
    logic       release_bus;
    logic       pick_valid;
    logic [1:0] pick;

    assign req         = M_WE | M_RD;
    assign busy        = (state_q == ST_BUSY);
    assign own_we      = M_WE[owner_q];
    assign own_rd      = M_RD[owner_q];
    assign own_req     = own_we | own_rd;
    assign own_ack     = busy & (S_WRAck | S_RDAck);
    assign burst_done  = (burst_arr[owner_q] == 12'd0) | M_BurstLast[owner_q];
    // The watchdog only fires on a live request; a dropped request releases silently instead.
    assign timeout_hit = WDOG_EN & busy & own_req & ~own_ack & (wdog_q == WDOG_LAST);
    assign release_bus = (own_ack & burst_done) | timeout_hit | (~own_req & ~own_ack);

    // Round-robin: scan from last_q+4 down to last_q+1 so the nearest successor wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick       = last_q + 2'(k);
            end
        end
    end

    always_comb begin
        S_Addr    = '0;
        S_BE      = '0;
        S_WE      = 1'b0;
        S_RD      = 1'b0;
        S_DataOut = '0;
        M_WRAck   = '0;
        M_RDAck   = '0;
        M_DataIn  = timeout_hit ? ERR_DATA : S_DataIn;
        if (busy) begin
            S_Addr           = addr_arr[owner_q];
            S_BE             = be_arr[owner_q];
            S_WE             = own_we;
            S_RD             = own_rd;
            S_DataOut        = dout_arr[owner_q];
            M_WRAck[owner_q] = S_WRAck | (timeout_hit & ~own_rd);
            M_RDAck[owner_q] = S_RDAck | (timeout_hit & own_rd);
        end
    end

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        wdog_d  = wdog_q;
        error_d = error_q | timeout_hit;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    owner_d = pick;
                    grant_d = 4'b0001 << pick;
                    wdog_d  = '0;
                end
            end
            ST_BUSY: begin
                if (release_bus) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                    wdog_d  = '0;
                end else if (own_ack) begin
                    wdog_d = '0;
                end else if (WDOG_EN) begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            grant_q <= '0;
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign Grant = grant_q;
    assign Error = error_q;

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Randomised and directed bench for vproc_bus_arbiter (TIMEOUT=8) against a transaction-level model.
module tb_vproc_bus_arbiter;

    localparam int unsigned TO  = 8;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic         clk;
    logic         n_reset;
    logic [255:0] m_addr;
    logic [31:0]  m_be;
    logic [3:0]   m_we;
    logic [3:0]   m_rd;
    logic [255:0] m_dout;
    logic [47:0]  m_burst;
    logic [3:0]   m_last;
    logic [63:0]  m_din;
    logic [3:0]   m_wrack;
    logic [3:0]   m_rdack;
    logic [63:0]  s_addr;
    logic [7:0]   s_be;
    logic         s_we;
    logic         s_rd;
    logic [63:0]  s_dout;
    logic [63:0]  s_din;
    logic         s_wrack;
    logic         s_rdack;
    logic [3:0]   grant;
    logic         error;

    int checks = 0;
    int errors = 0;

    // Model state: owner index (-1 when nobody holds the bus), last owner, quiet BUSY cycles, sticky error.
    int mo_owner;
    int mo_last;
    int mo_cnt;
    bit mo_err;

    vproc_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .Clk(clk), .nReset(n_reset),
        .M_Addr(m_addr), .M_BE(m_be), .M_WE(m_we), .M_RD(m_rd),
        .M_DataOut(m_dout), .M_Burst(m_burst), .M_BurstLast(m_last),
        .M_DataIn(m_din), .M_WRAck(m_wrack), .M_RDAck(m_rdack),
        .S_Addr(s_addr), .S_BE(s_be), .S_WE(s_we), .S_RD(s_rd), .S_DataOut(s_dout),
        .S_DataIn(s_din), .S_WRAck(s_wrack), .S_RDAck(s_rdack),
        .Grant(grant), .Error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic rand_data();
        for (int i = 0; i < 8; i++) begin
            m_addr[32*i +: 32] = $urandom;
            m_dout[32*i +: 32] = $urandom;
        end
        m_be  = $urandom;
        s_din = {$urandom, $urandom};
    endtask

    task automatic model_reset();
        mo_owner = -1;
        mo_last  = 3;
        mo_cnt   = 0;
        mo_err   = 1'b0;
    endtask

    // Called at a negedge with control inputs already set: checks this cycle, advances the model, returns at next negedge.
    task automatic step();
        logic [137:0] e_bus;
        logic [63:0]  e_din;
        logic [3:0]   e_grant, e_wrack, e_rdack;
        bit           to, ack, rel, o_req, found;
        int           o;
        rand_data();
        #1;
        o       = mo_owner;
        e_bus   = '0;
        e_grant = '0;
        e_wrack = '0;
        e_rdack = '0;
        e_din   = s_din;
        to      = 1'b0;
        rel     = 1'b0;
        ack     = 1'b0;
        if (o >= 0) begin
            o_req      = m_we[o] | m_rd[o];
            ack        = s_wrack | s_rdack;
            e_grant[o] = 1'b1;
            e_bus      = {m_addr[64*o +: 64], m_be[8*o +: 8], m_we[o], m_rd[o], m_dout[64*o +: 64]};
            to         = (mo_cnt == TO - 1) && !ack && o_req;
            e_wrack[o] = s_wrack | (to & !m_rd[o]);
            e_rdack[o] = s_rdack | (to & m_rd[o]);
            if (to) e_din = ERR;
            rel = (ack && (m_burst[12*o +: 12] == 12'd0 || m_last[o])) || to || (!o_req && !ack);
        end
        checks++;
        if (grant !== e_grant) begin
            errors++;
            $display("FAIL grant @%0t: got %b expected %b", $time, grant, e_grant);
        end
        checks++;
        if ({s_addr, s_be, s_we, s_rd, s_dout} !== e_bus) begin
            errors++;
            $display("FAIL slave_bus @%0t: got %h expected %h", $time, {s_addr, s_be, s_we, s_rd, s_dout}, e_bus);
        end
        checks++;
        if ({m_wrack, m_rdack} !== {e_wrack, e_rdack}) begin
            errors++;
            $display("FAIL acks @%0t: got wr=%b rd=%b expected wr=%b rd=%b", $time, m_wrack, m_rdack, e_wrack, e_rdack);
        end
        checks++;
        if (m_din !== e_din) begin
            errors++;
            $display("FAIL data_in @%0t: got %h expected %h", $time, m_din, e_din);
        end
        checks++;
        if (error !== mo_err) begin
            errors++;
            $display("FAIL error @%0t: got %b expected %b", $time, error, mo_err);
        end
        @(posedge clk);
        if (o < 0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && (m_we[(mo_last + k) % 4] | m_rd[(mo_last + k) % 4])) begin
                    found    = 1'b1;
                    mo_owner = (mo_last + k) % 4;
                    mo_cnt   = 0;
                end
            end
        end else if (rel) begin
            mo_last  = o;
            mo_owner = -1;
            if (to) mo_err = 1'b1;
        end else begin
            mo_cnt = ack ? 0 : mo_cnt + 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        m_we    = '0;
        m_rd    = '0;
        m_burst = '0;
        m_last  = '0;
        s_wrack = 1'b0;
        s_rdack = 1'b0;
        rand_data();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_reset = 1'b0;
        m_rd    = 4'hF;
        s_wrack = 1'b1;
        s_rdack = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || s_we !== 1'b0 || s_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: got grant=%b we=%b rd=%b expected 0000 0 0", grant, s_we, s_rd);
        end
        checks++;
        if (m_wrack !== 4'b0 || m_rdack !== 4'b0) begin
            errors++;
            $display("FAIL reset_acks: got wr=%b rd=%b expected 0000 0000", m_wrack, m_rdack);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b expected 0", error);
        end
        @(negedge clk);
        n_reset = 1'b1;
        m_rd    = '0;
        s_wrack = 1'b0;
        s_rdack = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_two_masters();
        do_reset();
        m_rd = 4'b0101;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL pair_first: got %b expected 0001", grant);
        end
        s_rdack = 1'b1;
        step();
        m_rd[0] = 1'b0;
        s_rdack = 1'b0;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL pair_gap: got %b expected 0000", grant);
        end
        step();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL pair_second: got %b expected 0100", grant);
        end
        s_rdack = 1'b1;
        step();
        m_rd    = '0;
        s_rdack = 1'b0;
        step();
    endtask

    task automatic test_burst();
        do_reset();
        m_we            = 4'b0010;
        m_rd            = 4'b1000;
        m_burst[12 +: 12] = 12'd4;
        step();
        for (int beat = 1; beat <= 4; beat++) begin
            checks++;
            if (grant !== 4'b0010) begin
                errors++;
                $display("FAIL burst_hold beat %0d: got %b expected 0010", beat, grant);
            end
            s_wrack   = 1'b1;
            m_last[1] = (beat == 4);
            step();
            s_wrack = 1'b0;
            m_last  = '0;
            if (beat < 4) step();
        end
        m_we = '0;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL burst_gap: got %b expected 0000", grant);
        end
        step();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL burst_next: got %b expected 1000", grant);
        end
        s_rdack = 1'b1;
        step();
        s_rdack = 1'b0;
        m_rd    = '0;
        m_burst = '0;
        step();
    endtask

    task automatic test_all_four();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int exp_cnt[4]   = '{2, 1, 1, 1};
        int rd_cnt[4]    = '{0, 0, 0, 0};
        do_reset();
        m_rd    = 4'hF;
        s_rdack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (grant != 4'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (grant[i]) order.push_back(i);
                    if (m_rdack[i]) rd_cnt[i]++;
                end
            end
            step();
        end
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants expected 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_cnt[i] != exp_cnt[i]) begin
                errors++;
                $display("FAIL rr_acks[%0d]: got %0d expected %0d", i, rd_cnt[i], exp_cnt[i]);
            end
        end
        m_rd    = '0;
        s_rdack = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        m_rd = 4'b0100;
        step();
        repeat (TO - 1) step();
        #1;
        checks++;
        if (m_rdack !== 4'b0100 || m_din !== ERR) begin
            errors++;
            $display("FAIL timeout_ack: got rd=%b data=%h expected 0100 %h", m_rdack, m_din, ERR);
        end
        step();
        checks++;
        if (error !== 1'b1 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_release: got err=%b grant=%b expected 1 0000", error, grant);
        end
        m_rd = '0;
        repeat (2) step();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got %b expected 1", error);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_rd              = 4'b0100;
        m_burst[24 +: 12] = 12'd3;
        step();
        s_rdack = 1'b1;
        step();
        m_rd = 4'b0101;
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || s_rd !== 1'b0 || s_we !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bus: got grant=%b rd=%b we=%b expected 0000 0 0", grant, s_rd, s_we);
        end
        checks++;
        if (m_rdack !== 4'b0 || m_wrack !== 4'b0) begin
            errors++;
            $display("FAIL midreset_acks: got rd=%b wr=%b expected 0000 0000", m_rdack, m_wrack);
        end
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;
        s_rdack = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_winner: got %b expected 0001", grant);
        end
        m_rd    = '0;
        m_burst = '0;
        repeat (2) step();
    endtask

    task automatic test_idle_ack();
        do_reset();
        s_wrack = 1'b1;
        s_rdack = 1'b1;
        repeat (3) begin
            #1;
            checks++;
            if (m_wrack !== 4'b0 || m_rdack !== 4'b0) begin
                errors++;
                $display("FAIL idle_ack: got wr=%b rd=%b expected 0000 0000", m_wrack, m_rdack);
            end
            step();
        end
        s_wrack = 1'b0;
        s_rdack = 1'b0;
    endtask

    task automatic test_random();
        bit stall;
        do_reset();
        stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) stall = ($urandom_range(2) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) begin
                    m_we[i] = 1'($urandom_range(1));
                    m_rd[i] = 1'($urandom_range(1));
                end
                m_burst[12*i +: 12] = ($urandom_range(2) == 0) ? 12'd0 : 12'($urandom_range(5));
            end
            m_last  = 4'($urandom_range(15)) & 4'($urandom_range(15));
            s_wrack = stall ? 1'b0 : 1'($urandom_range(1));
            s_rdack = stall ? 1'b0 : 1'($urandom_range(1));
            step();
        end
        m_we    = '0;
        m_rd    = '0;
        s_wrack = 1'b0;
        s_rdack = 1'b0;
        step();
    endtask

    initial begin
        n_reset = 1'b0;
        m_we    = '0;
        m_rd    = '0;
        m_burst = '0;
        m_last  = '0;
        s_wrack = 1'b0;
        s_rdack = 1'b0;
        rand_data();
        model_reset();
        test_reset();
        test_two_masters();
        test_burst();
        test_all_four();
        test_timeout();
        test_reset_mid_burst();
        test_idle_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
